// File: rtl/t03_dpu_pkg.sv
// Shared types, geometry constants, RGB332 palette and hit-test helpers for the sprite renderer.
package t03_dpu_pkg;

    localparam int POS_SHIFT = 1;
    localparam int SPR_W     = 16;
    localparam int SPR_H     = 32;
    localparam int ATK_W     = 12;
    localparam int GROUND_Y  = 400;
    localparam int HB_Y      = 8;
    localparam int HB_H      = 8;
    localparam int HB_SEG    = 8;
    localparam int HB_X0     = 16;
    localparam int H_ACT     = 640;
    localparam int FLASH_FR  = 8;

    typedef enum logic [2:0] {
        GS_TITLE = 3'd0,
        GS_FIGHT = 3'd1,
        GS_P1WIN = 3'd2,
        GS_P2WIN = 3'd3
    } game_state_t;

    typedef enum logic [1:0] {
        PS_IDLE   = 2'd0,
        PS_MOVE   = 2'd1,
        PS_ATTACK = 2'd2,
        PS_BLOCK  = 2'd3
    } player_state_t;

    localparam logic [7:0] TITLE  = 8'h4B;
    localparam logic [7:0] P1_WIN = 8'hE0;
    localparam logic [7:0] P2_WIN = 8'h03;
    localparam logic [7:0] SKY    = 8'h5F;
    localparam logic [7:0] GROUND = 8'h8C;
    localparam logic [7:0] BAR    = 8'h1C;
    localparam logic [7:0] ATK    = 8'hF0;
    localparam logic [7:0] BLOCK  = 8'h92;
    localparam logic [7:0] WHITE  = 8'hFF;
    localparam logic [7:0] BLACK  = 8'h00;

    // Index 0 is the rightmost entry.
    localparam logic [3:0][7:0] PAL1 = {8'hA0, 8'hE8, 8'hE4, 8'hC0};
    localparam logic [3:0][7:0] PAL2 = {8'h0F, 8'h0B, 8'h17, 8'h13};

    typedef struct packed {
        game_state_t   gs;
        player_state_t p1_st;
        player_state_t p2_st;
        logic [3:0]    p1_hp;
        logic [3:0]    p2_hp;
        logic [10:0]   x1;
        logic [10:0]   y1;
        logic [10:0]   x2;
        logic [10:0]   y2;
        logic          p1_left;
        logic          p2_left;
    } shadow_t;

    typedef struct packed {
        logic          valid;
        game_state_t   gs;
        player_state_t p1_st;
        player_state_t p2_st;
        logic          p1_white;
        logic          p2_white;
        logic          p1_atk;
        logic          p1_body;
        logic          p2_atk;
        logic          p2_body;
        logic          bar;
        logic          ground;
    } hit_t;

    function automatic logic signed [11:0] screen_pos(input logic [10:0] c);
        logic [11:0] t;
        t = {1'b0, c};
        return signed'(t << POS_SHIFT);
    endfunction

    function automatic logic in_range(input logic signed [11:0] v, lo, hi);
        return (v >= lo) && (v < hi);
    endfunction

    function automatic logic body_hit(input logic signed [11:0] h, v, px, py);
        return in_range(h, px, px + 12'(SPR_W)) && in_range(v, py, py + 12'(SPR_H));
    endfunction

    // A left-facing box near the screen edge clamps at column 0 instead of wrapping.
    function automatic logic atk_hit(input logic signed [11:0] h, v, px, py, input logic left);
        logic signed [11:0] lo;
        logic signed [11:0] hi;
        if (left) begin
            lo = px - 12'(ATK_W);
            hi = px;
        end else begin
            lo = px + 12'(SPR_W);
            hi = lo + 12'(ATK_W);
        end
        if (lo < 0) lo = '0;
        return in_range(h, lo, hi) && in_range(v, py + 12'(SPR_H / 4), py + 12'(SPR_H / 2));
    endfunction

endpackage

// File: rtl/t03_dpu_flash.sv
// Per-player damage flash: remembers last frame's health and runs a frame down-counter on a drop.
module t03_dpu_flash
    import t03_dpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start_i,
    input  logic [3:0] health_i,
    output logic       white_o
);

    logic [3:0] prev_q, prev_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        if (frame_start_i) begin
            prev_d = health_i;
            if (health_i < prev_q) begin
                cnt_d = 4'(FLASH_FR);
            end else if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 4'd0;
            cnt_q  <= 4'd0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

    // Blink pattern: white only while bit 1 of the counter is set.
    assign white_o = (cnt_q != 4'd0) && cnt_q[1];

endmodule

// File: rtl/t03_dpu_sprite_render.sv
// Pixel colour stage: per-frame shadow of game state, hit tests, two-stage pipe and priority mux.
module t03_dpu_sprite_render
    import t03_dpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  gameState,
    input  logic [1:0]  p1State,
    input  logic [1:0]  p2State,
    input  logic [3:0]  p1health,
    input  logic [3:0]  p2health,
    input  logic [10:0] x1,
    input  logic [10:0] y1,
    input  logic [10:0] x2,
    input  logic [10:0] y2,
    input  logic        p1Left,
    input  logic        p2Left,
    input  logic        frame_start,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        pix_valid,
    output logic [7:0]  rgb_out,
    output logic        rgb_valid
);

    shadow_t    shadow_q, shadow_d;
    hit_t       hit_q, hit_d;
    logic [7:0] rgb_q, rgb_d;
    logic       valid_q;
    logic       p1_white, p2_white;

    // Game inputs only land in the shadow at vblank, so a frame never tears.
    always_comb begin
        shadow_d = shadow_q;
        if (frame_start) begin
            shadow_d.gs      = game_state_t'(gameState);
            shadow_d.p1_st   = player_state_t'(p1State);
            shadow_d.p2_st   = player_state_t'(p2State);
            shadow_d.p1_hp   = p1health;
            shadow_d.p2_hp   = p2health;
            shadow_d.x1      = x1;
            shadow_d.y1      = y1;
            shadow_d.x2      = x2;
            shadow_d.y2      = y2;
            shadow_d.p1_left = p1Left;
            shadow_d.p2_left = p2Left;
        end
    end

    t03_dpu_flash u_flash1 (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (frame_start),
        .health_i      (p1health),
        .white_o       (p1_white)
    );

    t03_dpu_flash u_flash2 (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (frame_start),
        .health_i      (p2health),
        .white_o       (p2_white)
    );

    logic signed [11:0] h_s, v_s, p1_x, p1_y, p2_x, p2_y, p1_len, p2_len;
    logic               bar_rows;

    assign h_s      = signed'({1'b0, hcount});
    assign v_s      = signed'({1'b0, vcount});
    assign p1_x     = screen_pos(shadow_q.x1);
    assign p1_y     = screen_pos(shadow_q.y1);
    assign p2_x     = screen_pos(shadow_q.x2);
    assign p2_y     = screen_pos(shadow_q.y2);
    assign p1_len   = signed'(12'(shadow_q.p1_hp) * 12'(HB_SEG));
    assign p2_len   = signed'(12'(shadow_q.p2_hp) * 12'(HB_SEG));
    assign bar_rows = in_range(v_s, 12'(HB_Y), 12'(HB_Y + HB_H));

    // Stage 1 input: hit flags plus everything the colour mux needs from the current shadow.
    always_comb begin
        hit_d          = '0;
        hit_d.valid    = pix_valid;
        hit_d.gs       = shadow_q.gs;
        hit_d.p1_st    = shadow_q.p1_st;
        hit_d.p2_st    = shadow_q.p2_st;
        hit_d.p1_white = p1_white;
        hit_d.p2_white = p2_white;
        hit_d.p1_body  = body_hit(h_s, v_s, p1_x, p1_y);
        hit_d.p2_body  = body_hit(h_s, v_s, p2_x, p2_y);
        hit_d.p1_atk   = (shadow_q.p1_st == PS_ATTACK) &&
                         atk_hit(h_s, v_s, p1_x, p1_y, shadow_q.p1_left);
        hit_d.p2_atk   = (shadow_q.p2_st == PS_ATTACK) &&
                         atk_hit(h_s, v_s, p2_x, p2_y, shadow_q.p2_left);
        hit_d.bar      = bar_rows &&
                         (in_range(h_s, 12'(HB_X0), 12'(HB_X0) + p1_len) ||
                          in_range(h_s, 12'(H_ACT - HB_X0) - p2_len, 12'(H_ACT - HB_X0)));
        hit_d.ground   = v_s >= 12'(GROUND_Y);
    end

    // Stage 2 input: priority mux, forced to zero for blank pixels.
    always_comb begin
        rgb_d = BLACK;
        case (hit_q.gs)
            GS_TITLE: rgb_d = TITLE;
            GS_P1WIN: rgb_d = P1_WIN;
            GS_P2WIN: rgb_d = P2_WIN;
            GS_FIGHT: begin
                if (hit_q.p1_atk)        rgb_d = ATK;
                else if (hit_q.p1_body)  rgb_d = hit_q.p1_white ? WHITE :
                                                 (hit_q.p1_st == PS_BLOCK) ? BLOCK : PAL1[hit_q.p1_st];
                else if (hit_q.p2_atk)   rgb_d = ATK;
                else if (hit_q.p2_body)  rgb_d = hit_q.p2_white ? WHITE :
                                                 (hit_q.p2_st == PS_BLOCK) ? BLOCK : PAL2[hit_q.p2_st];
                else if (hit_q.bar)      rgb_d = BAR;
                else if (hit_q.ground)   rgb_d = GROUND;
                else                     rgb_d = SKY;
            end
            default: rgb_d = BLACK;
        endcase
        if (!hit_q.valid) rgb_d = BLACK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            hit_q    <= '0;
            rgb_q    <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            hit_q    <= hit_d;
            rgb_q    <= rgb_d;
            valid_q  <= hit_q.valid;
        end
    end

    assign rgb_out   = rgb_q;
    assign rgb_valid = valid_q;

endmodule

// File: tb/tb_t03_dpu_sprite_render.sv
// Directed bench for the sprite renderer: hand-computed colours at chosen scan points.
module tb_t03_dpu_sprite_render;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  gameState = '0;
    logic [1:0]  p1State = '0, p2State = '0;
    logic [3:0]  p1health = '0, p2health = '0;
    logic [10:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic        p1Left = 1'b0, p2Left = 1'b0;
    logic        frame_start = 1'b0;
    logic [10:0] hcount = '0, vcount = '0;
    logic        pix_valid = 1'b0;
    logic [7:0]  rgb_out;
    logic        rgb_valid;

    int compared   = 0;
    int mismatched = 0;

    t03_dpu_sprite_render dut (
        .clk         (clk),
        .rst         (rst),
        .gameState   (gameState),
        .p1State     (p1State),
        .p2State     (p2State),
        .p1health    (p1health),
        .p2health    (p2health),
        .x1          (x1),
        .y1          (y1),
        .x2          (x2),
        .y2          (y2),
        .p1Left      (p1Left),
        .p2Left      (p2Left),
        .frame_start (frame_start),
        .hcount      (hcount),
        .vcount      (vcount),
        .pix_valid   (pix_valid),
        .rgb_out     (rgb_out),
        .rgb_valid   (rgb_valid)
    );

    always #5 clk = ~clk;

    // One pixel through the two-stage pipe; the result is read two edges later.
    task automatic samplePixel(input int h, input int v, output logic [7:0] c, output logic vld);
        @(negedge clk);
        hcount    = 11'(h);
        vcount    = 11'(v);
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        c   = rgb_out;
        vld = rgb_valid;
    endtask

    task automatic pulseFrame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] c;
        logic       vld;
        #1 rst = 1'b1;
        pix_valid = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (rgb_out !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_rgb: got %h want 00", rgb_out);
        end
        compared++;
        if (rgb_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_valid: got %b want 0", rgb_valid);
        end
        rst = 1'b0;
        pix_valid = 1'b0;
        pulseFrame();
        samplePixel(100, 100, c, vld);
        compared++;
        if (c !== 8'h4B || vld !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_title: rgb=%h valid=%b want rgb=4b valid=1", c, vld);
        end
    endtask

    task automatic test_fight_basic();
        int         hs[5] = '{32, 48, 32, 512, 200};
        int         vs[5] = '{64, 64, 400, 64, 100};
        logic [7:0] ex[5] = '{8'hC0, 8'h5F, 8'h8C, 8'h13, 8'h5F};
        logic [7:0] c;
        logic       vld;
        gameState = 3'd1;
        x1 = 11'h010; y1 = 11'h020;
        x2 = 11'h100; y2 = 11'h020;
        pulseFrame();
        for (int i = 0; i < 5; i++) begin
            samplePixel(hs[i], vs[i], c, vld);
            compared++;
            if (c !== ex[i] || vld !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL fight[%0d] (%0d,%0d): rgb=%h valid=%b want rgb=%h valid=1",
                         i, hs[i], vs[i], c, vld, ex[i]);
            end
        end
    endtask

    task automatic test_shadow();
        logic [7:0] c;
        logic       vld;
        x1 = 11'h040;
        samplePixel(32, 64, c, vld);
        compared++;
        if (c !== 8'hC0) begin
            mismatched++;
            $display("[TB] FAIL shadow_hold: got %h want c0", c);
        end
        pulseFrame();
        samplePixel(32, 64, c, vld);
        compared++;
        if (c !== 8'h5F) begin
            mismatched++;
            $display("[TB] FAIL shadow_old_pos: got %h want 5f", c);
        end
        samplePixel(128, 64, c, vld);
        compared++;
        if (c !== 8'hC0) begin
            mismatched++;
            $display("[TB] FAIL shadow_new_pos: got %h want c0", c);
        end
        x1 = 11'h010;
        pulseFrame();
    endtask

    task automatic test_flash_and_bars();
        int         hs[8] = '{16, 47, 48, 15, 623, 608, 607, 608};
        int         vs[8] = '{8, 8, 8, 8, 8, 15, 8, 16};
        logic [7:0] ex[8] = '{8'h1C, 8'h1C, 8'h5F, 8'h5F, 8'h1C, 8'h1C, 8'h5F, 8'h5F};
        logic       wh[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] c;
        logic       vld;
        p1health = 4'd5;
        p2health = 4'd2;
        pulseFrame();
        samplePixel(32, 64, c, vld);
        compared++;
        if (c !== 8'hC0) begin
            mismatched++;
            $display("[TB] FAIL flash_on_increase: got %h want c0", c);
        end
        samplePixel(55, 8, c, vld);
        compared++;
        if (c !== 8'h1C) begin
            mismatched++;
            $display("[TB] FAIL bar_hp5_edge: got %h want 1c", c);
        end
        p1health = 4'd4;
        pulseFrame();
        for (int i = 0; i < 8; i++) begin
            samplePixel(hs[i], vs[i], c, vld);
            compared++;
            if (c !== ex[i]) begin
                mismatched++;
                $display("[TB] FAIL bar[%0d] (%0d,%0d): got %h want %h", i, hs[i], vs[i], c, ex[i]);
            end
        end
        for (int k = 0; k < 9; k++) begin
            samplePixel(32, 64, c, vld);
            compared++;
            if (c !== (wh[k] ? 8'hFF : 8'hC0)) begin
                mismatched++;
                $display("[TB] FAIL flash_frame[%0d]: got %h want %h", k, c, wh[k] ? 8'hFF : 8'hC0);
            end
            pulseFrame();
        end
    endtask

    task automatic test_attack();
        int         hs[10] = '{0, 7, 8, 0, 1000, 0, 16, 27, 28, 15};
        int         vs[10] = '{72, 79, 72, 80, 72, 71, 72, 72, 72, 72};
        logic [7:0] ex[10] = '{8'hF0, 8'hF0, 8'hE8, 8'h5F, 8'h5F, 8'h5F, 8'hF0, 8'hF0, 8'h5F, 8'hE8};
        logic [7:0] c;
        logic       vld;
        p1State = 2'd2;
        p1Left  = 1'b1;
        x1 = 11'h004; y1 = 11'h020;
        p2State = 2'd3;
        pulseFrame();
        for (int i = 0; i < 10; i++) begin
            if (i == 6) begin
                p1Left = 1'b0;
                x1 = 11'h000;
                pulseFrame();
            end
            samplePixel(hs[i], vs[i], c, vld);
            compared++;
            if (c !== ex[i]) begin
                mismatched++;
                $display("[TB] FAIL attack[%0d] (%0d,%0d): got %h want %h", i, hs[i], vs[i], c, ex[i]);
            end
        end
        samplePixel(512, 64, c, vld);
        compared++;
        if (c !== 8'h92) begin
            mismatched++;
            $display("[TB] FAIL p2_block: got %h want 92", c);
        end
    endtask

    task automatic test_back_to_back();
        int         hs[5] = '{16, 100, 100, 512, 20};
        int         vs[5] = '{72, 200, 450, 64, 8};
        logic [7:0] ex[5] = '{8'hF0, 8'h5F, 8'h8C, 8'h92, 8'h1C};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                compared++;
                if (i < 7 && (rgb_out !== ex[i-2] || rgb_valid !== 1'b1)) begin
                    mismatched++;
                    $display("[TB] FAIL b2b[%0d]: rgb=%h valid=%b want rgb=%h valid=1",
                             i - 2, rgb_out, rgb_valid, ex[i-2]);
                end else if (i == 7 && (rgb_out !== 8'h00 || rgb_valid !== 1'b0)) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_idle: rgb=%h valid=%b want rgb=00 valid=0", rgb_out, rgb_valid);
                end
            end
            if (i < 5) begin
                hcount = 11'(hs[i]);
                vcount = 11'(vs[i]);
                pix_valid = 1'b1;
            end else begin
                pix_valid = 1'b0;
            end
        end
    endtask

    task automatic test_frame_edge();
        @(negedge clk);
        gameState   = 3'd2;
        hcount      = 11'd100;
        vcount      = 11'd200;
        frame_start = 1'b1;
        pix_valid   = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        pix_valid = 1'b0;
        compared++;
        if (rgb_out !== 8'h5F) begin
            mismatched++;
            $display("[TB] FAIL edge_old_shadow: got %h want 5f", rgb_out);
        end
        @(negedge clk);
        compared++;
        if (rgb_out !== 8'hE0) begin
            mismatched++;
            $display("[TB] FAIL edge_new_shadow: got %h want e0", rgb_out);
        end
    endtask

    task automatic test_win_states();
        logic [2:0] gs[4] = '{3'd2, 3'd3, 3'd5, 3'd7};
        logic [7:0] ex[4] = '{8'hE0, 8'h03, 8'h00, 8'h00};
        logic [7:0] c;
        logic       vld;
        for (int i = 0; i < 4; i++) begin
            gameState = gs[i];
            pulseFrame();
            samplePixel(16, 72, c, vld);
            compared++;
            if (c !== ex[i] || vld !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL win[%0d] gs=%0d: rgb=%h valid=%b want rgb=%h valid=1",
                         i, gs[i], c, vld, ex[i]);
            end
            samplePixel(639, 479, c, vld);
            compared++;
            if (c !== ex[i]) begin
                mismatched++;
                $display("[TB] FAIL win_corner[%0d]: got %h want %h", i, c, ex[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] c;
        logic       vld;
        gameState = 3'd2;
        pulseFrame();
        @(negedge clk);
        hcount = 11'd50;
        vcount = 11'd50;
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if (rgb_valid !== 1'b0 || rgb_out !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL midframe_abort: rgb=%h valid=%b want rgb=00 valid=0", rgb_out, rgb_valid);
        end
        samplePixel(100, 100, c, vld);
        compared++;
        if (c !== 8'h4B || vld !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midframe_title: rgb=%h valid=%b want rgb=4b valid=1", c, vld);
        end
    endtask

    initial begin
        test_reset();
        test_fight_basic();
        test_shadow();
        test_flash_and_bars();
        test_attack();
        test_back_to_back();
        test_frame_edge();
        test_win_states();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
